spi_pixel_master: RTL and testbench



---
 rtl/spi_master_pkg.sv | 21 ++
 rtl/spi_clk_div.sv | 32 +++
 rtl/spi_pixel_master.sv | 194 +++++++++++++++++++
 tb/tb_spi_pixel_master.sv | 282 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/spi_master_pkg.sv
// Shared definitions for the SPI pixel master: FSM state encoding and
// default sizing constants.
package spi_master_pkg;

    // Widest pixel word carried over the SPI pixel port.
    localparam int MAX_PIXEL_BITS      = 24;

    // Default clk_i cycles per SCK half-period (the core needs >= 4).
    localparam int SPI_CLK_DIV_DEFAULT = 4;

    // Frame sequencing states.
    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_SETUP = 3'd1,
        ST_HIGH  = 3'd2,
        ST_LOW   = 3'd3,
        ST_HOLD  = 3'd4,
        ST_GAP   = 3'd5
    } spi_master_state_t;

endpackage

// File: rtl/spi_clk_div.sv
// Shared phase timer: counts CLK_DIV cycles per SPI phase and flags the
// last cycle of each phase. Reloads itself so consecutive phases chain.
module spi_clk_div
    import spi_master_pkg::*;
#(
    parameter int CLK_DIV = SPI_CLK_DIV_DEFAULT
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic restart_i,
    output logic phase_done_o
);

    localparam int               CNT_W  = $clog2(CLK_DIV);
    localparam logic [CNT_W-1:0] RELOAD = CNT_W'(CLK_DIV - 1);

    logic [CNT_W-1:0] r_cnt;

    // Down-counter: reload on restart or on reaching zero, else decrement.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_cnt <= RELOAD;
        end else if (restart_i || (r_cnt == '0)) begin
            r_cnt <= RELOAD;
        end else begin
            r_cnt <= r_cnt - CNT_W'(1);
        end
    end

    assign phase_done_o = (r_cnt == '0);

endmodule

// File: rtl/spi_pixel_master.sv
// SPI mode-0 host controller: takes one pixel per valid/ready handshake,
// shifts it out MSB-first and captures the slave's word in the same frame.
module spi_pixel_master
    import spi_master_pkg::*;
#(
    parameter int PIXEL_BITS = MAX_PIXEL_BITS,
    parameter int CLK_DIV    = SPI_CLK_DIV_DEFAULT
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic [PIXEL_BITS-1:0] tx_px_i,
    input  logic                  tx_valid_i,
    output logic                  tx_ready_o,
    output logic [PIXEL_BITS-1:0] rx_px_o,
    output logic                  rx_valid_o,
    output logic                  busy_o,
    output logic                  spi_sck_o,
    output logic                  spi_cs_o,
    output logic                  spi_sdo_o,
    input  logic                  spi_sdi_i
);

    localparam int               BIT_W    = $clog2(PIXEL_BITS);
    localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(PIXEL_BITS - 1);

    spi_master_state_t     r_state;
    spi_master_state_t     w_next_state;
    logic [PIXEL_BITS-1:0] r_tx;
    logic [PIXEL_BITS-1:0] w_tx_next;
    logic [PIXEL_BITS-1:0] r_rx;
    logic [PIXEL_BITS-1:0] r_rx_px;
    logic [BIT_W-1:0]      r_bit;
    logic                  r_rx_valid;
    logic                  r_sck;
    logic                  r_cs;
    logic                  r_sdo;
    logic                  w_sck_next;
    logic                  w_cs_next;
    logic                  w_sdo_next;
    logic                  w_hs;
    logic                  w_phase_done;
    logic                  w_last_bit;
    logic                  w_high_end;
    logic                  w_hold_end;

    // Reset masks ready, so a handshake coinciding with reset is dropped.
    assign tx_ready_o = (r_state == ST_IDLE) & ~rst_i;
    assign w_hs       = tx_valid_i & tx_ready_o;
    assign w_last_bit = (r_bit == LAST_BIT);
    assign w_high_end = (r_state == ST_HIGH) & w_phase_done;
    assign w_hold_end = (r_state == ST_HOLD) & w_phase_done;

    spi_clk_div #(
        .CLK_DIV      (CLK_DIV)
    ) u_clk_div (
        .clk_i        (clk_i),
        .rst_i        (rst_i),
        .restart_i    (w_hs),
        .phase_done_o (w_phase_done)
    );

    // State register; reset aborts any frame in progress.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state logic: each non-idle phase lasts one phase-timer period.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_hs) w_next_state = ST_SETUP;
                else      w_next_state = ST_IDLE;
            end
            ST_SETUP: begin
                if (w_phase_done) w_next_state = ST_HIGH;
                else              w_next_state = ST_SETUP;
            end
            ST_HIGH: begin
                if (w_phase_done && w_last_bit) w_next_state = ST_HOLD;
                else if (w_phase_done)          w_next_state = ST_LOW;
                else                            w_next_state = ST_HIGH;
            end
            ST_LOW: begin
                if (w_phase_done) w_next_state = ST_HIGH;
                else              w_next_state = ST_LOW;
            end
            ST_HOLD: begin
                if (w_phase_done) w_next_state = ST_GAP;
                else              w_next_state = ST_HOLD;
            end
            ST_GAP: begin
                if (w_phase_done) w_next_state = ST_IDLE;
                else              w_next_state = ST_GAP;
            end
            default: w_next_state = ST_IDLE;
        endcase
    end

    // Next transmit shift value: load at handshake, advance when SCK falls.
    always_comb begin
        w_tx_next = r_tx;
        if (w_hs) begin
            w_tx_next = tx_px_i;
        end else if (w_high_end && !w_last_bit) begin
            w_tx_next = r_tx << 1;
        end else begin
            w_tx_next = r_tx;
        end
    end

    // SPI pin values for the state being entered, so the pins are registered
    // in lock-step with the state register.
    always_comb begin
        w_sck_next = 1'b0;
        w_cs_next  = 1'b1;
        w_sdo_next = 1'b0;
        case (w_next_state)
            ST_SETUP, ST_LOW, ST_HOLD: begin
                w_sck_next = 1'b0;
                w_cs_next  = 1'b0;
                w_sdo_next = w_tx_next[PIXEL_BITS-1];
            end
            ST_HIGH: begin
                w_sck_next = 1'b1;
                w_cs_next  = 1'b0;
                w_sdo_next = w_tx_next[PIXEL_BITS-1];
            end
            default: begin
                w_sck_next = 1'b0;
                w_cs_next  = 1'b1;
                w_sdo_next = 1'b0;
            end
        endcase
    end

    // Registered SPI pins and transmit shift register.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_sck <= 1'b0;
            r_cs  <= 1'b1;
            r_sdo <= 1'b0;
            r_tx  <= '0;
        end else begin
            r_sck <= w_sck_next;
            r_cs  <= w_cs_next;
            r_sdo <= w_sdo_next;
            r_tx  <= w_tx_next;
        end
    end

    // Bit counter and receive shift; MISO is sampled in the last HIGH cycle
    // so a slave resynchronising SCK has had time to drive it.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_bit <= '0;
            r_rx  <= '0;
        end else begin
            if (w_hs) begin
                r_bit <= '0;
            end else if (w_high_end && !w_last_bit) begin
                r_bit <= r_bit + BIT_W'(1);
            end
            if (w_high_end) begin
                r_rx <= {r_rx[PIXEL_BITS-2:0], spi_sdi_i};
            end
        end
    end

    // Publish the received word as CS rises; aborted frames never get here.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_rx_px    <= '0;
            r_rx_valid <= 1'b0;
        end else begin
            r_rx_valid <= w_hold_end;
            if (w_hold_end) begin
                r_rx_px <= r_rx;
            end
        end
    end

    assign spi_sck_o  = r_sck;
    assign spi_cs_o   = r_cs;
    assign spi_sdo_o  = r_sdo;
    assign rx_px_o    = r_rx_px;
    assign rx_valid_o = r_rx_valid;
    assign busy_o     = (r_state != ST_IDLE);

endmodule

// File: tb/tb_spi_pixel_master.sv
// Scoreboard bench for spi_pixel_master with a behavioural mode-0 slave.
module tb_spi_pixel_master;

    localparam int N = 24;
    localparam int D = 4;
    // Frame length in cycles from CS fall to IDLE, plus the IDLE handshake cycle.
    localparam int PERIOD = D * (2 * N + 2) + 1;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic [N-1:0] tx_px = '0;
    logic         tx_valid = 1'b0;
    logic         tx_ready;
    logic [N-1:0] rx_px;
    logic         rx_valid;
    logic         busy;
    logic         sck;
    logic         cs;
    logic         sdo;
    logic         sdi = 1'b0;

    spi_pixel_master #(
        .PIXEL_BITS (N),
        .CLK_DIV    (D)
    ) dut (
        .clk_i      (clk),
        .rst_i      (rst),
        .tx_px_i    (tx_px),
        .tx_valid_i (tx_valid),
        .tx_ready_o (tx_ready),
        .rx_px_o    (rx_px),
        .rx_valid_o (rx_valid),
        .busy_o     (busy),
        .spi_sck_o  (sck),
        .spi_cs_o   (cs),
        .spi_sdo_o  (sdo),
        .spi_sdi_i  (sdi)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    // Scoreboard queues: slave return words, words the slave must capture,
    // words rx_px_o must present.
    logic [N-1:0] ret_q[$];
    logic [N-1:0] exp_slave_q[$];
    logic [N-1:0] exp_rx_q[$];

    // Slave / monitor state.
    int           neg_cnt = 0;
    int           cs_fall_cyc = 0;
    int           cs_rise_cyc = 0;
    int           last_rise = 0;
    int           last_hs = 0;
    int           rise_cnt = 0;
    int           lag = 0;
    int           lag_cnt = -1;
    logic [N-1:0] s_ret = '0;
    logic [N-1:0] s_rx = '0;
    bit           prev_cs = 1'b1;
    bit           prev_sck = 1'b0;
    bit           prev_ready = 1'b0;
    bit           chk_gap = 1'b0;
    bit           abort_frame = 1'b0;
    bit           end_pending = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Slave model and output monitor, evaluated away from the active edge.
    always @(negedge clk) begin
        bit cs_fall, cs_rise, sck_rise, sck_fall;
        logic [N-1:0] exp_w;
        neg_cnt++;
        cs_fall  = prev_cs && !cs;
        cs_rise  = !prev_cs && cs;
        sck_rise = !prev_sck && sck && !cs;
        sck_fall = prev_sck && !sck && !cs;

        if (tx_valid && tx_ready) begin
            if (chk_gap) check("handshake_period", neg_cnt - last_hs, PERIOD);
            last_hs = neg_cnt;
        end

        if (cs_fall) begin
            s_ret = (ret_q.size() > 0) ? ret_q.pop_front() : '0;
            sdi   = s_ret[N-1];
            s_ret = s_ret << 1;
            s_rx  = '0;
            rise_cnt = 0;
            lag_cnt  = -1;
            if (chk_gap) check("cs_high_gap", neg_cnt - cs_rise_cyc, D + 1);
            cs_fall_cyc = neg_cnt;
        end

        if (sck_rise) begin
            s_rx = {s_rx[N-2:0], sdo};
            if (rise_cnt == 0) check("first_sck_rise", neg_cnt - cs_fall_cyc, D);
            else               check("sck_spacing", neg_cnt - last_rise, 2 * D);
            last_rise = neg_cnt;
            rise_cnt++;
        end

        if (sck_fall) lag_cnt = lag;
        if (lag_cnt == 0) begin
            sdi   = s_ret[N-1];
            s_ret = s_ret << 1;
            lag_cnt = -1;
        end else if (lag_cnt > 0) begin
            lag_cnt--;
        end

        if (cs_rise) begin
            cs_rise_cyc = neg_cnt;
            if (abort_frame) begin
                abort_frame = 1'b0;
            end else begin
                check("sck_rise_count", rise_cnt, N);
                check("cs_low_len", neg_cnt - cs_fall_cyc, D * (2 * N + 1));
                if (exp_slave_q.size() == 0) begin
                    check("unexpected_frame", 32'd1, 32'd0);
                end else begin
                    exp_w = exp_slave_q.pop_front();
                    check("slave_capture", s_rx, exp_w);
                end
                end_pending = 1'b1;
            end
        end

        if (rx_valid) begin
            check("rx_valid_at_cs_rise", {30'd0, prev_cs, cs}, 32'd1);
            if (exp_rx_q.size() == 0) begin
                check("unexpected_rx_valid", rx_px, 32'hDEAD);
            end else begin
                exp_w = exp_rx_q.pop_front();
                check("rx_px", rx_px, exp_w);
            end
        end

        if (tx_ready && !prev_ready && end_pending) begin
            check("ready_after_cs_rise", neg_cnt - cs_rise_cyc, D);
            end_pending = 1'b0;
        end

        prev_cs    = cs;
        prev_sck   = sck;
        prev_ready = tx_ready;
    end

    // Offer one pixel; the slave answers with ret. tx_px_i is scrambled right
    // after the handshake so the frame must carry the captured value.
    task automatic send(input logic [N-1:0] px, input logic [N-1:0] ret,
                        input bit complete, input bit keep);
        int guard;
        guard = 0;
        @(posedge clk); #2;
        tx_px    = px;
        tx_valid = 1'b1;
        ret_q.push_back(ret);
        if (complete) begin
            exp_slave_q.push_back(px);
            exp_rx_q.push_back(ret);
        end
        forever begin
            @(negedge clk);
            if (tx_ready) break;
            guard++;
            if (guard > 1000) begin
                check("handshake_timeout", 32'd1, 32'd0);
                tx_valid = 1'b0;
                return;
            end
        end
        @(posedge clk); #2;
        tx_px    = N'($urandom());
        tx_valid = keep;
    endtask

    // Wait for all outstanding frames to finish, bounded.
    task automatic drain();
        int guard;
        guard = 0;
        while (exp_rx_q.size() != 0 || exp_slave_q.size() != 0 || busy) begin
            @(posedge clk);
            guard++;
            if (guard > 3000) begin
                check("drain_timeout", exp_rx_q.size(), 32'd0);
                return;
            end
        end
        repeat (2) @(posedge clk);
    endtask

    initial begin
        int guard;
        // Reset held for three cycles.
        repeat (3) begin
            @(negedge clk);
            check("rst_cs", cs, 1'b1);
            check("rst_sck", sck, 1'b0);
            check("rst_sdo", sdo, 1'b0);
            check("rst_ready", tx_ready, 1'b0);
            check("rst_busy", busy, 1'b0);
            check("rst_rx_valid", rx_valid, 1'b0);
            check("rst_rx_px", rx_px, 32'd0);
        end
        @(posedge clk); #2;
        rst = 1'b0;
        @(negedge clk);
        check("ready_after_rst", tx_ready, 1'b1);

        // Single frame.
        send(24'hA5C3F0, 24'h00003C, 1'b1, 1'b0);
        drain();
        check("rx_px_held", rx_px, 24'h00003C);

        // Back-to-back with tx_valid held high.
        send(24'h111111, 24'h0ABCDE, 1'b1, 1'b1);
        @(negedge clk); #1;
        chk_gap = 1'b1;
        send(24'h222222, 24'h123456, 1'b1, 1'b1);
        send(24'h333333, 24'hFEDCBA, 1'b1, 1'b0);
        @(negedge clk); #1;
        chk_gap = 1'b0;
        drain();

        // Reset after the 10th SCK rise, then a clean frame.
        send(24'h5A5A5A, 24'h777777, 1'b0, 1'b0);
        guard = 0;
        while (!(rise_cnt >= 10 && !cs) && guard < 1000) begin
            @(posedge clk);
            guard++;
        end
        check("mid_frame_reached", {31'd0, (guard < 1000)}, 32'd1);
        #2;
        rst = 1'b1;
        abort_frame = 1'b1;
        @(posedge clk); #1;
        check("abort_cs_high", cs, 1'b1);
        check("abort_sck_low", sck, 1'b0);
        check("abort_idle", busy, 1'b0);
        #1;
        rst = 1'b0;
        send(24'h0F0F0F, 24'h0C0C0C, 1'b1, 1'b0);
        drain();

        // Lagging slave.
        lag = 3;
        send(N'($urandom()), 24'hFFFFFF, 1'b1, 1'b0);
        drain();
        send(N'($urandom()), 24'h800001, 1'b1, 1'b0);
        drain();

        // Randomised frames, slave lag and idle gaps.
        for (int k = 0; k < 8; k++) begin
            lag = $urandom_range(0, 3);
            send(N'($urandom()), N'($urandom()), 1'b1, 1'b0);
            repeat ($urandom_range(0, 5)) @(posedge clk);
            drain();
        end

        check("left_rx_expect", exp_rx_q.size(), 32'd0);
        check("left_slave_expect", exp_slave_q.size(), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    // Global time bound.
    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, %0d failed so far", fails);
        $fatal(1);
    end

endmodule
